// File: rtl/kyber_cit_pkg.sv
// -----------------------------------------------------------------------------
// kyber_cit_pkg
// Shared constants and types for the Kyber ciphertext packer / unpacker pair.
// The ciphertext packer and state_unpack_cit both take their group geometry,
// their destination base addresses and their state encoding from here, so
// the two directions stay exact inverses of each other.
//
// Contents:
//   KYBER_N, KYBER_Q, DU, DV, DATA_W  - algorithm constants
//   CT0_SIZE, CT1_SIZE                - packed image widths
//   BP_GROUP_W / V_GROUP_W            - bits per packed group (40 / 24)
//   BP_GROUPS / V_GROUPS              - groups per polynomial (64 / 32)
//   BP0_BASE, BP1_BASE, V_BASE        - first (highest) destination address
//   unpack_state_e                    - FSM state encoding
//   decompress_coef()                 - (x*q + 2^(d-1)) >> d, 12-bit result
// -----------------------------------------------------------------------------
package kyber_cit_pkg;

    localparam int KYBER_N  = 256;
    localparam int KYBER_Q  = 3329;
    localparam int DU       = 10;
    localparam int DV       = 3;
    localparam int DATA_W   = 12;

    localparam int CT0_SIZE = 2560;
    localparam int CT1_SIZE = 768;

    // A Bp RAM word carries 4 coefficients, a V RAM word carries 8.
    localparam int BP_LANES   = 4;
    localparam int V_LANES    = 8;
    localparam int BP_GROUP_W = BP_LANES * DU;   // 40
    localparam int V_GROUP_W  = V_LANES * DV;    // 24
    localparam int BP_GROUPS  = CT0_SIZE / BP_GROUP_W;  // 64
    localparam int V_GROUPS   = CT1_SIZE / V_GROUP_W;   // 32

    // Groups are taken MSB-first, so the first group lands on the highest
    // address of each region.
    localparam int BP0_BASE = 63;
    localparam int BP1_BASE = 127;
    localparam int V_BASE   = 31;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UNP_BP0 = 3'd1,
        ST_UNP_BP1 = 3'd2,
        ST_UNP_V   = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_DONE    = 3'd5
    } unpack_state_e;

    // Decompress one coefficient of width d (d <= 10). The 22-bit
    // intermediate holds 1023*3329 + 512 without overflow; the result is
    // always <= KYBER_Q-1 so the 12-bit truncation is lossless.
    function automatic logic [DATA_W-1:0] decompress_coef(
        input logic [9:0]  x,
        input int unsigned d
    );
        return DATA_W'(((22'(x) * 22'(KYBER_Q)) + (22'd1 << (d - 1))) >> d);
    endfunction

endpackage

// File: rtl/state_unpack_cit__decompress.sv
// -----------------------------------------------------------------------------
// state_unpack_cit__decompress
// Purely combinational, lane-parallel decompressor. Each lane takes a d-bit
// compressed coefficient and returns the 12-bit value (x*q + 2^(d-1)) >> d.
// Used twice by state_unpack_cit: 4 lanes with d=10 for Bp, 8 lanes with
// d=3 for V.
//
// Parameters:
//   D      - compressed coefficient width (1..10)
//   LANES  - number of coefficients handled in parallel
// Ports:
//   packed_data  in   LANES*D   lane j in bits [D*j+D-1 : D*j]
//   coef_data    out  LANES*12  lane j in bits [12*j+11 : 12*j]
// -----------------------------------------------------------------------------
module state_unpack_cit__decompress
    import kyber_cit_pkg::*;
#(
    parameter int D     = 10,
    parameter int LANES = 4
) (
    input  logic [LANES*D-1:0]      packed_data,
    output logic [LANES*DATA_W-1:0] coef_data
);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [9:0]        comp_s;
        logic [DATA_W-1:0] coef_s;

        // Zero-extend the lane to the helper's 10-bit input and decompress.
        always_comb begin
            comp_s = 10'(packed_data[j*D +: D]);
            coef_s = decompress_coef(comp_s, D);
        end

        assign coef_data[j*DATA_W +: DATA_W] = coef_s;
    end

endmodule

// File: rtl/state_unpack_cit.sv
// -----------------------------------------------------------------------------
// state_unpack_cit
// Decryption-side inverse of the ciphertext packer. Walks the packed b'[0],
// b'[1] and v images one group per cycle (MSB group first), decompresses
// each group and writes it into the Bp / V coefficient RAMs with one
// register stage of latency.
//
// Sequence after an accepted enable (cycle 0):
//   cycles   1..64  UNP_BP0  b'[0] groups -> Bp addr 63..0   (written 2..65)
//   cycles  65..128 UNP_BP1  b'[1] groups -> Bp addr 127..64 (written 66..129)
//   cycles 129..160 UNP_V    v groups     -> V  addr 31..0   (written 130..161)
//   cycle  161      FLUSH    last V write leaves the pipeline
//   cycle  162      DONE     Function_done pulse
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   enable              start pulse, only honoured in IDLE
//   i_Ciphertext0_0/1   packed b'[0]/b'[1] (2560 b), held stable during a run
//   i_Ciphertext1       packed v (768 b), held stable during a run
//   Bp_WEn/WAd/WData    Bp RAM write port (4 x 12-bit coefficients per word)
//   V_WEn/WAd/WData     V RAM write port  (8 x 12-bit coefficients per word)
//   Function_done       one-cycle completion pulse
//
// Optional build macro STATE_UNPACK_CIT_BUSY_EN adds:
//   busy                high from cycle 1 through the DONE cycle
//   o_ignored_start     sticky: enable seen while busy; cleared by reset or by
//                       an accepted enable
// -----------------------------------------------------------------------------
module state_unpack_cit
    import kyber_cit_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [CT0_SIZE-1:0]           i_Ciphertext0_0,
    input  logic [CT0_SIZE-1:0]           i_Ciphertext0_1,
    input  logic [CT1_SIZE-1:0]           i_Ciphertext1,
    output logic                          Bp_WEn,
    output logic [6:0]                    Bp_WAd,
    output logic [BP_LANES*DATA_W-1:0]    Bp_WData,
    output logic                          V_WEn,
    output logic [4:0]                    V_WAd,
    output logic [V_LANES*DATA_W-1:0]     V_WData,
    output logic                          Function_done
`ifdef STATE_UNPACK_CIT_BUSY_EN
    ,
    output logic                          busy,
    output logic                          o_ignored_start
`endif
);

    unpack_state_e state_r;
    unpack_state_e state_nxt_s;
    logic [5:0]    g_r;
    logic [5:0]    g_nxt_s;

    logic [CT0_SIZE-1:0]           bp_src_s;
    logic [11:0]                   bp_base_s;
    logic [BP_GROUP_W-1:0]         bp_slice_s;
    logic [9:0]                    v_base_s;
    logic [V_GROUP_W-1:0]          v_slice_s;
    logic [BP_LANES*DATA_W-1:0]    bp_coef_s;
    logic [V_LANES*DATA_W-1:0]     v_coef_s;
    logic                          bp_active_s;
    logic                          v_active_s;
    logic [6:0]                    bp_addr_s;
    logic [4:0]                    v_addr_s;

    // FSM state and group counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            g_r     <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            g_r     <= g_nxt_s;
        end
    end

    // Next-state logic; the group counter restarts at 0 on every phase change.
    always_comb begin
        state_nxt_s = state_r;
        g_nxt_s     = g_r;
        case (state_r)
            ST_IDLE: begin
                g_nxt_s = 6'd0;
                if (enable) begin
                    state_nxt_s = ST_UNP_BP0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_UNP_BP0: begin
                if (g_r == 6'(BP_GROUPS - 1)) begin
                    state_nxt_s = ST_UNP_BP1;
                    g_nxt_s     = 6'd0;
                end else begin
                    g_nxt_s     = g_r + 6'd1;
                end
            end
            ST_UNP_BP1: begin
                if (g_r == 6'(BP_GROUPS - 1)) begin
                    state_nxt_s = ST_UNP_V;
                    g_nxt_s     = 6'd0;
                end else begin
                    g_nxt_s     = g_r + 6'd1;
                end
            end
            ST_UNP_V: begin
                if (g_r == 6'(V_GROUPS - 1)) begin
                    state_nxt_s = ST_FLUSH;
                    g_nxt_s     = 6'd0;
                end else begin
                    g_nxt_s     = g_r + 6'd1;
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_DONE;
                g_nxt_s     = 6'd0;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                g_nxt_s     = 6'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                g_nxt_s     = 6'd0;
            end
        endcase
    end

    // Group slicing and destination addressing for the current cycle.
    // Group g of a b' image starts at bit 2559-40g and of v at 767-24g.
    always_comb begin
        bp_active_s = (state_r == ST_UNP_BP0) || (state_r == ST_UNP_BP1);
        v_active_s  = (state_r == ST_UNP_V);

        if (state_r == ST_UNP_BP1) begin
            bp_src_s  = i_Ciphertext0_1;
            bp_addr_s = 7'(BP1_BASE) - 7'(g_r);
        end else begin
            bp_src_s  = i_Ciphertext0_0;
            bp_addr_s = 7'(BP0_BASE) - 7'(g_r);
        end

        bp_base_s  = 12'(CT0_SIZE - 1) - (12'(g_r) * 12'(BP_GROUP_W));
        bp_slice_s = bp_src_s[bp_base_s -: BP_GROUP_W];

        // Only the low 5 counter bits are meaningful in the v phase; using
        // them keeps the base inside the image in every other phase too.
        v_base_s   = 10'(CT1_SIZE - 1) - (10'(g_r[4:0]) * 10'(V_GROUP_W));
        v_slice_s  = i_Ciphertext1[v_base_s -: V_GROUP_W];
        v_addr_s   = 5'(V_BASE) - g_r[4:0];
    end

    state_unpack_cit__decompress #(
        .D     (DU),
        .LANES (BP_LANES)
    ) u_bp_decompress (
        .packed_data (bp_slice_s),
        .coef_data   (bp_coef_s)
    );

    state_unpack_cit__decompress #(
        .D     (DV),
        .LANES (V_LANES)
    ) u_v_decompress (
        .packed_data (v_slice_s),
        .coef_data   (v_coef_s)
    );

    // Output register stage; address and data hold while the strobe is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Bp_WEn        <= 1'b0;
            Bp_WAd        <= 7'd0;
            Bp_WData      <= '0;
            V_WEn         <= 1'b0;
            V_WAd         <= 5'd0;
            V_WData       <= '0;
            Function_done <= 1'b0;
        end else begin
            Bp_WEn        <= bp_active_s;
            V_WEn         <= v_active_s;
            Function_done <= (state_r == ST_FLUSH);
            if (bp_active_s) begin
                Bp_WAd   <= bp_addr_s;
                Bp_WData <= bp_coef_s;
            end
            if (v_active_s) begin
                V_WAd   <= v_addr_s;
                V_WData <= v_coef_s;
            end
        end
    end

`ifdef STATE_UNPACK_CIT_BUSY_EN
    // Busy follows the next state so it rises the cycle after the accepted
    // enable and falls the cycle after DONE; ignored-start is sticky.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy            <= 1'b0;
            o_ignored_start <= 1'b0;
        end else begin
            busy <= (state_nxt_s != ST_IDLE);
            if (enable && (state_r == ST_IDLE)) begin
                o_ignored_start <= 1'b0;
            end else if (enable && busy) begin
                o_ignored_start <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/state_unpack_cit.md
Name: state_unpack_cit

Overview:
Decryption-side inverse of the ciphertext packer. Takes the packed ciphertext (two 2560-bit polyvec-b' images and one 768-bit v image), slices each compressed group, and decompresses it (du=10, dv=3) back to 12-bit coefficients. Results are written into the Bp and V coefficient RAMs that feed the decryption NTT and arithmetic path. Group ordering and address mapping are the exact inverse of the packer.

Parameters:
KYBER_N, 256, coefficients per polynomial
KYBER_Q, 3329, modulus
DU, 10, b' compressed coefficient width
DV, 3, v compressed coefficient width
data_Width, 12, decompressed coefficient width
Ciphertext0_Size, 2560, bits per b' polynomial image
Ciphertext1_Size, 768, bits of v image

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
enable  in  1  start pulse, sampled only in IDLE
i_Ciphertext0_0  in  2560  packed b'[0]; must stay stable from enable until Function_done
i_Ciphertext0_1  in  2560  packed b'[1]; same stability rule
i_Ciphertext1  in  768  packed v; same stability rule
Bp_WEn  out  1  Bp RAM write strobe
Bp_WAd  out  7  Bp RAM word address; 4 coefficients per word
Bp_WData  out  48  coefficient j in bits [12j+11:12j]
V_WEn  out  1  V RAM write strobe
V_WAd  out  5  V RAM word address; 8 coefficients per word
V_WData  out  96  coefficient j in bits [12j+11:12j]
Function_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, FSM IDLE, group counter g = 0. Reset mid-operation aborts immediately. No partial write is completed.
- FSM states: IDLE -> UNP_BP0 (64 cycles) -> UNP_BP1 (64) -> UNP_V (32) -> FLUSH (1) -> DONE (1) -> IDLE.
- Group counter g is 6 bits. It clears on every phase change.
- Cycle numbering: cycle 0 is enable=1 in IDLE. Cycles 1-64 are UNP_BP0, 65-128 UNP_BP1, 129-160 UNP_V, 161 FLUSH. Cycle 162 has Function_done=1, then IDLE.
- UNP_BP0, group g: slice i_Ciphertext0_0[2559-40g -: 40]. Compressed coefficient j = bits [10j+9:10j] of the slice. Destination address 63-g.
- UNP_BP1, group g: same slicing from i_Ciphertext0_1. Destination address 127-g.
- UNP_V, group g: slice i_Ciphertext1[767-24g -: 24]. Coefficient j = bits [3j+2:3j]. Destination address 31-g.
- Decompress: y = (x*KYBER_Q + 2^(d-1)) >> d, with d = DU or DV. Intermediate width is 22 bits; y is truncated to 12 bits. Output is always <= 3328.
- Pipeline: one register stage. The slice taken in cycle n appears as WEn, WAd and WData in cycle n+1.
  - Bp writes occur in cycles 2-129.
  - V writes occur in cycles 130-161.
  - There are never simultaneous Bp and V writes.
- When a WEn is 0, its WAd and WData hold their last value.
- enable outside IDLE, including the DONE cycle, is ignored. No restart and no error.
- Back-to-back operation: enable in the cycle after DONE starts a new run.

Optional Feature:
STATE_UNPACK_CIT_BUSY_EN
- Defined: adds output busy (1 bit).
  - busy = 1 from cycle 1 through cycle 162 inclusive, 0 in IDLE and in reset.
  - Adds output o_ignored_start (1 bit), a sticky flag set when enable=1 while busy=1, cleared by reset or by an accepted enable.
- Undefined: neither port exists. Behaviour is otherwise identical.

Decomposition:
- Package kyber_cit_pkg:
  - KYBER_Q, KYBER_N, DU, DV
  - group sizes (40, 24) and groups per polynomial (64, 32)
  - state encoding typedef
  - base addresses 63, 127, 31
- The packer migrates to the same package.
- Sub-module state_unpack_cit__decompress: parametric d and lane count. Combinational multiply-round-shift per lane, shared by the Bp (4-lane, d=10) and V (8-lane, d=3) paths. Instantiated twice.

Test Plan:
- All-zero ciphertext, enable pulse -> 128 Bp writes (addr 63..0, then 127..64) and 32 V writes (addr 31..0), all data 0. Function_done=1 in cycle 162 only.
- i_Ciphertext0_0[2559:2520] = {10'd0,10'd512,10'd1,10'd1023} -> cycle 2: Bp_WEn=1, Bp_WAd=63, lanes j0..j3 = 3326, 3, 1665, 0.
- i_Ciphertext1[767:744] = coefficients j0..j7 = 7,4,1,0,0,0,0,0 -> cycle 130: V_WAd=31, lanes = 2913, 1665, 416, 0...
- Random ciphertext vs golden model: every address written exactly once and matches the model. Max output <= 3328.
- rst_n=0 in cycle 70 -> next cycle all outputs 0 and FSM IDLE. A new enable then restarts from address 63.
- enable re-asserted in cycles 50 and 162 -> ignored, single Function_done. With STATE_UNPACK_CIT_BUSY_EN: o_ignored_start=1 after cycle 50.
